kb_scancode_decoder: RTL and testbench
======================================

// Module: kb_scancode_decoder
// PURPOSE
//  Sits between the PS/2 byte receiver and the bash videoMemory stage.
//  Decodes PS/2 set-2 bytes (make/break, E0 extended, E1 pause) into key events.
//  Drives the scanCode/scanCode_E0/modifier/ASCII bus and a held newKey strobe,
//  which videoMemory edge-detects.
// PARAMETERS
//  NEWKEY_HOLD  4   cycles newKey stays high per event (>=2, for the 3-stage edge sync)
//  NEWKEY_GAP   4   minimum low cycles after newKey falls before the next event
//  PAUSE_SKIP   7   bytes discarded after E1
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous, active-high reset
//  ps2_data     in   8  head byte of the receiver FIFO
//  ps2_ready    in   1  FIFO non-empty, ps2_data valid
//  ps2_next     out  1  1-cycle pop pulse, FIFO advances
//  scanCode     out  8  last non-extended make code (0 after an extended make)
//  scanCode_E0  out  8  last extended make code (0 after a non-extended make)
//  shift        out  1  L(12) or R(59) shift held
//  ctrl         out  1  14 or E0 14 held
//  alt          out  1  11 or E0 11 held
//  capslock     out  1  toggle state
//  insert       out  1  toggle state
//  ASCII        out  8  ASCII of scanCode under shift^capslock
//  isASCIIkey   out  1  scanCode maps to a printable char (0x20..0x7E)
//  newKey       out  1  event strobe, NEWKEY_HOLD cycles
// BEHAVIOUR
//  Reset: every output 0; FSM in IDLE; held key cleared; pulse engine idle.
//  Pop: a byte is consumed in a cycle with ps2_ready=1, ps2_next=0, and the pulse engine idle.
//   ps2_next=1 on the following cycle. No pop while newKey is high or during the GAP.
//  FSM (consumed byte -> next state):
//   IDLE: E0->EXT, F0->BRK, E1->SKIP (cnt=PAUSE_SKIP), {00,AA,FA,FE,FF}->IDLE ignored,
//    other bytes -> make(code) and return to IDLE.
//   EXT:  F0->EXTBRK, E0/E1->IDLE drop, other bytes -> make({1,code}) and go to IDLE.
//   BRK / EXTBRK: any byte -> break({e,code}) and go to IDLE.
//   SKIP: decrement cnt per byte and go to IDLE at 0. Pause produces no events or modifier change.
//  make(k):
//   k is a modifier -> set its flag, no newKey.
//   k==58 (caps) and k!=held -> toggle capslock, no newKey.
//   k==E0 70 (insert) and k!=held -> toggle insert, no newKey.
//   k==held -> repeat (see CONFIGURATION).
//   Otherwise held=k, then in one cycle: update scanCode/scanCode_E0/ASCII/isASCIIkey,
//    and raise newKey.
//   All bus outputs are stable from the newKey rise until the next event.
//  break(k): clear the modifier flag (shift only when both L and R are released);
//   clear held if k==held; never newKey.
//  ASCII: letters upper iff shift^capslock; digits/symbols follow shift only; 29->0x20.
//   66, 5A, and all extended codes give isASCIIkey=0, ASCII=0.
//  Latency: consume cycle -> outputs and newKey registered on the next edge (1 cycle).
//  Simultaneous ps2_ready with an active pulse: the byte waits in the FIFO; no loss.
//  Async rst mid-pulse or mid-prefix: newKey drops immediately, FSM goes to IDLE,
//   toggles clear, partial sequence dropped.
// CONFIGURATION
//  KB_TYPEMATIC_EN defined: a repeated make of held fires a full newKey event.
//   Caps and insert repeats still do not re-toggle.
//  Undefined: a repeated make of held is consumed and ignored. One newKey per physical press.
// STRUCTURE
//  kb_defs (shared include/package): SC_BREAK=F0, SC_EXT=E0, SC_PAUSE=E1, SC_LSHIFT=12,
//   SC_RSHIFT=59, SC_CTRL=14, SC_ALT=11, SC_CAPS=58, SC_INSERT=70, SC_BKSP=66, SC_ENTER=5A,
//   plus FSM state encodings.
//   videoMemory reuses these.
//  Sub-module kb_ascii_rom: combinational (scanCode, shift, capslock) -> (ASCII, isASCIIkey).
//  Top holds the FSM, modifiers, held-key register, and the hold/gap pulse counter.
// TESTING
//  1. Bytes 1C, F0 1C -> one newKey (4 cycles high), scanCode=1C, ASCII=0x61,
//     isASCIIkey=1. The break produces no newKey.
//  2. 12, 1C, F0 1C, F0 12 -> ASCII=0x41, shift=1 during the event, then shift=0.
//     58 then 1C -> capslock=1, ASCII=0x41. With shift held, ASCII=0x61.
//  3. E0 75 -> scanCode_E0=75, scanCode=0, isASCIIkey=0. E0 70 -> insert toggles, no newKey.
//  4. 1C 1C 1C, no break -> 3 newKey events with KB_TYPEMATIC_EN, 1 without.
//     ps2_next never pulses during hold or gap.
//  5. E1 14 77 E1 F0 14 F0 77 then 16 -> only one event (scanCode=16, ASCII=0x31).
//     ctrl stays 0. AA and FA are ignored.
//  6. rst asserted between E0 and 75: newKey=0 and all outputs 0 at once.
//     A following 75 decodes as non-extended (scanCode=75).

Source files
------------

// File: rtl/kb_scancode_decoder_pkg.sv
// Shared PS/2 set-2 scan code constants and decoder state encodings.
// videoMemory imports the same definitions.
package kb_scancode_decoder_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_INSERT = 8'h70;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_ENTER  = 8'h5A;

  // Keys are carried as {extended, code} so E0-prefixed codes stay distinct.
  localparam logic [8:0] KEY_LSHIFT = {1'b0, SC_LSHIFT};
  localparam logic [8:0] KEY_RSHIFT = {1'b0, SC_RSHIFT};
  localparam logic [8:0] KEY_LCTRL  = {1'b0, SC_CTRL};
  localparam logic [8:0] KEY_RCTRL  = {1'b1, SC_CTRL};
  localparam logic [8:0] KEY_LALT   = {1'b0, SC_ALT};
  localparam logic [8:0] KEY_RALT   = {1'b1, SC_ALT};
  localparam logic [8:0] KEY_CAPS   = {1'b0, SC_CAPS};
  localparam logic [8:0] KEY_INSERT = {1'b1, SC_INSERT};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK,
    ST_SKIP
  } dec_state_t;

  typedef enum logic [1:0] {
    PE_IDLE,
    PE_HOLD,
    PE_GAP
  } pulse_state_t;

  // Keyboard status/ack bytes that carry no key information.
  function automatic logic is_noise_byte(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hFA) ||
           (b == 8'hFE) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/kb_scancode_decoder_ascii_rom.sv
// Combinational set-2 scan code to ASCII map under shift/capslock.
// Letters honour shift^capslock; digits and symbols follow shift only.
module kb_ascii_rom (
  input  logic [7:0] scan_code,
  input  logic       shift,
  input  logic       capslock,
  output logic [7:0] ascii,
  output logic       is_ascii_key
);

  logic [7:0] base_char;
  logic [7:0] shift_char;
  logic       is_letter;

  always_comb begin
    base_char  = 8'h00;
    shift_char = 8'h00;
    case (scan_code)
      8'h1C: base_char = "a";
      8'h32: base_char = "b";
      8'h21: base_char = "c";
      8'h23: base_char = "d";
      8'h24: base_char = "e";
      8'h2B: base_char = "f";
      8'h34: base_char = "g";
      8'h33: base_char = "h";
      8'h43: base_char = "i";
      8'h3B: base_char = "j";
      8'h42: base_char = "k";
      8'h4B: base_char = "l";
      8'h3A: base_char = "m";
      8'h31: base_char = "n";
      8'h44: base_char = "o";
      8'h4D: base_char = "p";
      8'h15: base_char = "q";
      8'h2D: base_char = "r";
      8'h1B: base_char = "s";
      8'h2C: base_char = "t";
      8'h3C: base_char = "u";
      8'h2A: base_char = "v";
      8'h1D: base_char = "w";
      8'h22: base_char = "x";
      8'h35: base_char = "y";
      8'h1A: base_char = "z";
      8'h16: begin base_char = "1"; shift_char = "!"; end
      8'h1E: begin base_char = "2"; shift_char = "@"; end
      8'h26: begin base_char = "3"; shift_char = "#"; end
      8'h25: begin base_char = "4"; shift_char = "$"; end
      8'h2E: begin base_char = "5"; shift_char = "%"; end
      8'h36: begin base_char = "6"; shift_char = "^"; end
      8'h3D: begin base_char = "7"; shift_char = "&"; end
      8'h3E: begin base_char = "8"; shift_char = "*"; end
      8'h46: begin base_char = "9"; shift_char = "("; end
      8'h45: begin base_char = "0"; shift_char = ")"; end
      8'h0E: begin base_char = 8'h60; shift_char = 8'h7E; end
      8'h4E: begin base_char = 8'h2D; shift_char = 8'h5F; end
      8'h55: begin base_char = 8'h3D; shift_char = 8'h2B; end
      8'h5D: begin base_char = 8'h5C; shift_char = 8'h7C; end
      8'h54: begin base_char = 8'h5B; shift_char = 8'h7B; end
      8'h5B: begin base_char = 8'h5D; shift_char = 8'h7D; end
      8'h4C: begin base_char = 8'h3B; shift_char = 8'h3A; end
      8'h52: begin base_char = 8'h27; shift_char = 8'h22; end
      8'h41: begin base_char = 8'h2C; shift_char = 8'h3C; end
      8'h49: begin base_char = 8'h2E; shift_char = 8'h3E; end
      8'h4A: begin base_char = 8'h2F; shift_char = 8'h3F; end
      8'h29: begin base_char = 8'h20; shift_char = 8'h20; end
      default: ;
    endcase
  end

  assign is_letter    = (base_char >= 8'h61) && (base_char <= 8'h7A);
  assign is_ascii_key = (base_char != 8'h00);

  always_comb begin
    ascii = base_char;
    if (is_letter) begin
      if (shift ^ capslock) ascii = base_char - 8'h20;
    end else if (shift) begin
      ascii = shift_char;
    end
  end

endmodule

// File: rtl/kb_scancode_decoder.sv
// PS/2 set-2 byte decoder: prefixes, modifiers, toggles and a held newKey strobe.
// Define KB_TYPEMATIC_EN to turn repeated makes of the held key into events.
module kb_scancode_decoder
  import kb_scancode_decoder_pkg::*;
#(
  parameter int NEWKEY_HOLD = 4,
  parameter int NEWKEY_GAP  = 4,
  parameter int PAUSE_SKIP  = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_data,
  input  logic       ps2_ready,
  output logic       ps2_next,
  output logic [7:0] scanCode,
  output logic [7:0] scanCode_E0,
  output logic       shift,
  output logic       ctrl,
  output logic       alt,
  output logic       capslock,
  output logic       insert,
  output logic [7:0] ASCII,
  output logic       isASCIIkey,
  output logic       newKey
);

  localparam int CNT_MAX = (NEWKEY_HOLD > NEWKEY_GAP) ? NEWKEY_HOLD : NEWKEY_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SKIP_W  = $clog2(PAUSE_SKIP + 1);

`ifdef KB_TYPEMATIC_EN
  localparam logic TYPEMATIC = 1'b1;
`else
  localparam logic TYPEMATIC = 1'b0;
`endif

  dec_state_t         state_q, state_d;
  logic [SKIP_W-1:0]  skip_q, skip_d;
  pulse_state_t       pe_q, pe_d;
  logic [CNT_W-1:0]   pe_cnt_q, pe_cnt_d;

  logic       consume;
  logic       do_make, do_break;
  logic [8:0] key;
  logic [8:0] held_q;
  logic       lshift_q, rshift_q, lctrl_q, rctrl_q, lalt_q, ralt_q;
  logic       is_mod, same_key;
  logic       take_held, toggle_caps, toggle_ins, fire;
  logic [7:0] next_scan, next_e0, rom_ascii;
  logic       rom_is_ascii;

  // Bytes are only taken while the strobe engine is fully idle, so a byte
  // arriving during hold or gap simply waits at the FIFO head.
  assign consume = ps2_ready && !ps2_next && (pe_q == PE_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      skip_q   <= '0;
      pe_q     <= PE_IDLE;
      pe_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      pe_q     <= pe_d;
      pe_cnt_q <= pe_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    do_make  = 1'b0;
    do_break = 1'b0;
    key      = {1'b0, ps2_data};
    if (consume) begin
      case (state_q)
        ST_IDLE: begin
          if (ps2_data == SC_EXT) begin
            state_d = ST_EXT;
          end else if (ps2_data == SC_BREAK) begin
            state_d = ST_BRK;
          end else if (ps2_data == SC_PAUSE) begin
            state_d = ST_SKIP;
            skip_d  = SKIP_W'(PAUSE_SKIP);
          end else if (!is_noise_byte(ps2_data)) begin
            do_make = 1'b1;
          end
        end
        ST_EXT: begin
          state_d = ST_IDLE;
          key     = {1'b1, ps2_data};
          if (ps2_data == SC_BREAK) begin
            state_d = ST_EXTBRK;
          end else if ((ps2_data != SC_EXT) && (ps2_data != SC_PAUSE)) begin
            do_make = 1'b1;
          end
        end
        ST_BRK: begin
          state_d  = ST_IDLE;
          do_break = 1'b1;
        end
        ST_EXTBRK: begin
          state_d  = ST_IDLE;
          key      = {1'b1, ps2_data};
          do_break = 1'b1;
        end
        ST_SKIP: begin
          if (skip_q <= SKIP_W'(1)) begin
            state_d = ST_IDLE;
            skip_d  = '0;
          end else begin
            skip_d = skip_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign is_mod = (key == KEY_LSHIFT) || (key == KEY_RSHIFT) ||
                  (key == KEY_LCTRL)  || (key == KEY_RCTRL)  ||
                  (key == KEY_LALT)   || (key == KEY_RALT);
  assign same_key = (key == held_q);

  // Caps and insert become the held key so their auto-repeat never re-toggles.
  always_comb begin
    take_held   = 1'b0;
    toggle_caps = 1'b0;
    toggle_ins  = 1'b0;
    fire        = 1'b0;
    if (do_make && !is_mod) begin
      take_held = 1'b1;
      if (key == KEY_CAPS) begin
        toggle_caps = !same_key;
      end else if (key == KEY_INSERT) begin
        toggle_ins = !same_key;
      end else begin
        fire = !same_key || TYPEMATIC;
      end
    end
  end

  assign next_scan = key[8] ? 8'h00 : key[7:0];
  assign next_e0   = key[8] ? key[7:0] : 8'h00;

  kb_ascii_rom u_ascii_rom (
    .scan_code    (next_scan),
    .shift        (shift),
    .capslock     (capslock),
    .ascii        (rom_ascii),
    .is_ascii_key (rom_is_ascii)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps2_next    <= 1'b0;
      held_q      <= '0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      lalt_q      <= 1'b0;
      ralt_q      <= 1'b0;
      capslock    <= 1'b0;
      insert      <= 1'b0;
      scanCode    <= '0;
      scanCode_E0 <= '0;
      ASCII       <= '0;
      isASCIIkey  <= 1'b0;
    end else begin
      ps2_next <= consume;
      if (take_held) begin
        held_q <= key;
      end else if (do_break && same_key) begin
        held_q <= '0;
      end
      if (toggle_caps) capslock <= ~capslock;
      if (toggle_ins)  insert   <= ~insert;
      if (do_make || do_break) begin
        case (key)
          KEY_LSHIFT: lshift_q <= do_make;
          KEY_RSHIFT: rshift_q <= do_make;
          KEY_LCTRL:  lctrl_q  <= do_make;
          KEY_RCTRL:  rctrl_q  <= do_make;
          KEY_LALT:   lalt_q   <= do_make;
          KEY_RALT:   ralt_q   <= do_make;
          default: ;
        endcase
      end
      if (fire) begin
        scanCode    <= next_scan;
        scanCode_E0 <= next_e0;
        ASCII       <= rom_ascii;
        isASCIIkey  <= rom_is_ascii;
      end
    end
  end

  assign shift = lshift_q | rshift_q;
  assign ctrl  = lctrl_q | rctrl_q;
  assign alt   = lalt_q | ralt_q;

  // Strobe engine: NEWKEY_HOLD cycles high, then NEWKEY_GAP cycles of enforced low.
  always_comb begin
    pe_d     = pe_q;
    pe_cnt_d = pe_cnt_q;
    case (pe_q)
      PE_IDLE: begin
        if (fire) begin
          pe_d     = PE_HOLD;
          pe_cnt_d = '0;
        end
      end
      PE_HOLD: begin
        if (pe_cnt_q == CNT_W'(NEWKEY_HOLD - 1)) begin
          pe_d     = PE_GAP;
          pe_cnt_d = '0;
        end else begin
          pe_cnt_d = pe_cnt_q + 1'b1;
        end
      end
      PE_GAP: begin
        if (pe_cnt_q == CNT_W'(NEWKEY_GAP - 1)) begin
          pe_d     = PE_IDLE;
          pe_cnt_d = '0;
        end else begin
          pe_cnt_d = pe_cnt_q + 1'b1;
        end
      end
      default: pe_d = PE_IDLE;
    endcase
  end

  assign newKey = (pe_q == PE_HOLD);

endmodule

// File: tb/tb_kb_scancode_decoder.sv
// Randomized and directed bench for kb_scancode_decoder against a byte-stream key model.
// Honours KB_TYPEMATIC_EN the same way as the design.
module tb_kb_scancode_decoder;

  localparam int NEWKEY_HOLD = 4;
  localparam int NEWKEY_GAP  = 4;

`ifdef KB_TYPEMATIC_EN
  localparam bit TYPEMATIC = 1'b1;
`else
  localparam bit TYPEMATIC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ps2_data;
  logic       ps2_ready;
  logic       ps2_next;
  logic [7:0] scanCode, scanCode_E0, ASCII;
  logic       shift, ctrl, alt, capslock, insert, isASCIIkey, newKey;

  kb_scancode_decoder #(
    .NEWKEY_HOLD (NEWKEY_HOLD),
    .NEWKEY_GAP  (NEWKEY_GAP),
    .PAUSE_SKIP  (7)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_data    (ps2_data),
    .ps2_ready   (ps2_ready),
    .ps2_next    (ps2_next),
    .scanCode    (scanCode),
    .scanCode_E0 (scanCode_E0),
    .shift       (shift),
    .ctrl        (ctrl),
    .alt         (alt),
    .capslock    (capslock),
    .insert      (insert),
    .ASCII       (ASCII),
    .isASCIIkey  (isASCIIkey),
    .newKey      (newKey)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] scan;
    logic [7:0] scan_e0;
    logic [7:0] ascii;
    logic       is_ascii;
    logic       shift;
    logic       ctrl;
    logic       alt;
    logic       caps;
    logic       ins;
  } key_event_t;

  key_event_t exp_q[$];
  logic [7:0] fifo_q[$];

  int compared   = 0;
  int mismatched = 0;
  int events_seen = 0;
  int pop_violations = 0;
  int hi_cnt = 0;
  int lo_cnt = 100;
  logic prev_nk = 1'b0;

  // Reference key state: a set of pressed modifiers, two toggles, the held key.
  bit m_lsh, m_rsh, m_lct, m_rct, m_lal, m_ral, m_caps, m_ins;
  logic [8:0] m_held;
  bit   pend_ext, pend_brk;
  int   skip_left;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46, 8'h45};
  logic [7:0] sym_codes [11] = '{8'h0E, 8'h4E, 8'h55, 8'h5D, 8'h54, 8'h5B, 8'h4C,
    8'h52, 8'h41, 8'h49, 8'h4A};
  string digit_lo = "1234567890";
  string digit_hi = "!@#$%^&*()";
  logic [7:0] sym_lo [11] = '{8'h60, 8'h2D, 8'h3D, 8'h5C, 8'h5B, 8'h5D, 8'h3B,
    8'h27, 8'h2C, 8'h2E, 8'h2F};
  logic [7:0] sym_hi [11] = '{8'h7E, 8'h5F, 8'h2B, 8'h7C, 8'h7B, 8'h7D, 8'h3A,
    8'h22, 8'h3C, 8'h3E, 8'h3F};

  logic [7:0] key_pool [22] = '{8'h1C, 8'h32, 8'h21, 8'h16, 8'h1E, 8'h45, 8'h0E, 8'h4E,
    8'h5D, 8'h4A, 8'h52, 8'h29, 8'h66, 8'h5A, 8'h0D, 8'h12, 8'h59, 8'h14, 8'h11,
    8'h58, 8'h1A, 8'h15};
  logic [7:0] ext_pool [10] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h70, 8'h14, 8'h11,
    8'h71, 8'h4A, 8'h5A};

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] refAscii(input logic [7:0] code, input bit sh, input bit cp);
    if (code == 8'h29) return 8'h20;
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == code) return (sh ^ cp) ? 8'(65 + i) : 8'(97 + i);
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == code) return sh ? digit_hi[i] : digit_lo[i];
    for (int i = 0; i < 11; i++)
      if (sym_codes[i] == code) return sh ? sym_hi[i] : sym_lo[i];
    return 8'h00;
  endfunction

  function automatic void modelReset();
    {m_lsh, m_rsh, m_lct, m_rct, m_lal, m_ral, m_caps, m_ins} = '0;
    m_held    = '0;
    pend_ext  = 1'b0;
    pend_brk  = 1'b0;
    skip_left = 0;
  endfunction

  function automatic void pushEvent(input logic [8:0] k);
    key_event_t e;
    e.scan     = k[8] ? 8'h00 : k[7:0];
    e.scan_e0  = k[8] ? k[7:0] : 8'h00;
    e.ascii    = refAscii(e.scan, m_lsh | m_rsh, m_caps);
    e.is_ascii = (e.ascii != 8'h00);
    e.shift    = m_lsh | m_rsh;
    e.ctrl     = m_lct | m_rct;
    e.alt      = m_lal | m_ral;
    e.caps     = m_caps;
    e.ins      = m_ins;
    exp_q.push_back(e);
  endfunction

  function automatic bit setModifier(input logic [8:0] k, input bit v);
    case (k)
      9'h012: m_lsh = v;
      9'h059: m_rsh = v;
      9'h014: m_lct = v;
      9'h114: m_rct = v;
      9'h011: m_lal = v;
      9'h111: m_ral = v;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic void modelMake(input logic [8:0] k);
    if (setModifier(k, 1'b1)) return;
    if (k == 9'h058 || k == 9'h170) begin
      if (k != m_held) begin
        if (k == 9'h058) m_caps = ~m_caps;
        else             m_ins  = ~m_ins;
        m_held = k;
      end
      return;
    end
    if (k == m_held) begin
      if (TYPEMATIC) pushEvent(k);
      return;
    end
    m_held = k;
    pushEvent(k);
  endfunction

  function automatic void modelBreak(input logic [8:0] k);
    void'(setModifier(k, 1'b0));
    if (k == m_held) m_held = '0;
  endfunction

  function automatic void modelByte(input logic [7:0] b);
    if (skip_left > 0) begin
      skip_left--;
    end else if (pend_brk) begin
      modelBreak({pend_ext, b});
      pend_ext = 1'b0;
      pend_brk = 1'b0;
    end else if (pend_ext) begin
      pend_ext = 1'b0;
      if (b == 8'hF0) begin
        pend_ext = 1'b1;
        pend_brk = 1'b1;
      end else if (b != 8'hE0 && b != 8'hE1) begin
        modelMake({1'b1, b});
      end
    end else begin
      if (b == 8'hE0) pend_ext = 1'b1;
      else if (b == 8'hF0) pend_brk = 1'b1;
      else if (b == 8'hE1) skip_left = 7;
      else if (!(b inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF})) modelMake({1'b0, b});
    end
  endfunction

  task automatic applyStimulus(input logic [7:0] b);
    fifo_q.push_back(b);
    modelByte(b);
  endtask

  // One clock of monitoring, sampled on the falling edge, plus FIFO head update.
  task automatic stepCycle();
    key_event_t e;
    @(negedge clk);
    if (newKey && !prev_nk) begin
      events_seen++;
      hi_cnt = 0;
      if (exp_q.size() == 0) begin
        checkOutput("spurious_event", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("ev_scanCode", scanCode, e.scan);
        checkOutput("ev_scanCode_E0", scanCode_E0, e.scan_e0);
        checkOutput("ev_ASCII", ASCII, e.ascii);
        checkOutput("ev_isASCIIkey", isASCIIkey, e.is_ascii);
        checkOutput("ev_mods", {shift, ctrl, alt, capslock, insert},
                    {e.shift, e.ctrl, e.alt, e.caps, e.ins});
      end
    end
    if (newKey) begin
      hi_cnt++;
      lo_cnt = 0;
    end else begin
      if (prev_nk) checkOutput("hold_len", hi_cnt, NEWKEY_HOLD);
      if (lo_cnt < 1000) lo_cnt++;
    end
    if (ps2_next && ((newKey && hi_cnt >= 2) || (!newKey && lo_cnt <= NEWKEY_GAP + 1)))
      pop_violations++;
    prev_nk = newKey;
    if (ps2_next) begin
      if (fifo_q.size() == 0) checkOutput("pop_empty", 1, 0);
      else void'(fifo_q.pop_front());
    end
    ps2_ready = (fifo_q.size() > 0);
    ps2_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic runIdle(input int budget);
    int n = 0;
    do begin
      stepCycle();
      n++;
    end while ((fifo_q.size() > 0 || newKey || ps2_next || lo_cnt <= NEWKEY_GAP + 2)
               && n < budget);
    if (n >= budget) checkOutput("timeout", 1, 0);
    checkOutput("events_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic applyReset();
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_newKey", newKey, 0);
    checkOutput("rst_outputs", {scanCode, scanCode_E0, ASCII, isASCIIkey, shift, ctrl,
                                alt, capslock, insert, ps2_next}, 0);
    modelReset();
    exp_q.delete();
    @(negedge clk);
    rst     = 1'b0;
    prev_nk = 1'b0;
    hi_cnt  = 0;
    lo_cnt  = 100;
  endtask

  task automatic randomToken();
    int sel;
    logic [7:0] k;
    sel = $urandom_range(0, 99);
    k   = key_pool[$urandom_range(0, 21)];
    if (sel < 40) begin
      applyStimulus(k);
    end else if (sel < 72) begin
      applyStimulus(8'hF0); applyStimulus(k);
    end else if (sel < 82) begin
      applyStimulus(8'hE0); applyStimulus(ext_pool[$urandom_range(0, 9)]);
    end else if (sel < 91) begin
      applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(ext_pool[$urandom_range(0, 9)]);
    end else if (sel < 94) begin
      foreach (ext_pool[i]) if (i < 1) ;
      applyStimulus(8'hE1); applyStimulus(8'h14); applyStimulus(8'h77); applyStimulus(8'hE1);
      applyStimulus(8'hF0); applyStimulus(8'h14); applyStimulus(8'hF0); applyStimulus(8'h77);
    end else if (sel < 97) begin
      applyStimulus(($urandom_range(0, 1) == 0) ? 8'hAA : 8'hFA);
    end else begin
      applyStimulus(8'($urandom));
    end
  endtask

  initial begin
    int base;
    rst       = 1'b1;
    ps2_data  = 8'h00;
    ps2_ready = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {scanCode, scanCode_E0, ASCII, isASCIIkey, shift, ctrl,
                                  alt, capslock, insert, newKey, ps2_next}, 0);
    rst = 1'b0;
    repeat (2) stepCycle();

    // Plain letter press and release
    base = events_seen;
    applyStimulus(8'h1C); applyStimulus(8'hF0); applyStimulus(8'h1C);
    runIdle(200);
    checkOutput("t1_events", events_seen - base, 1);
    checkOutput("t1_scanCode", scanCode, 8'h1C);
    checkOutput("t1_ascii", ASCII, 8'h61);
    checkOutput("t1_isascii", isASCIIkey, 1);

    // Shift and capslock interplay
    applyStimulus(8'h12); applyStimulus(8'h1C); applyStimulus(8'hF0); applyStimulus(8'h1C);
    applyStimulus(8'hF0); applyStimulus(8'h12);
    runIdle(200);
    checkOutput("t2_shift_ascii", ASCII, 8'h41);
    checkOutput("t2_shift_released", shift, 0);
    applyStimulus(8'h58); applyStimulus(8'hF0); applyStimulus(8'h58); applyStimulus(8'h1C);
    runIdle(200);
    checkOutput("t2_caps", capslock, 1);
    checkOutput("t2_caps_ascii", ASCII, 8'h41);
    applyStimulus(8'hF0); applyStimulus(8'h1C); applyStimulus(8'h12); applyStimulus(8'h1C);
    runIdle(200);
    checkOutput("t2_caps_shift_ascii", ASCII, 8'h61);
    applyStimulus(8'hF0); applyStimulus(8'h1C); applyStimulus(8'hF0); applyStimulus(8'h12);
    applyStimulus(8'h58); applyStimulus(8'hF0); applyStimulus(8'h58);
    runIdle(200);
    checkOutput("t2_caps_off", capslock, 0);

    // Extended key and insert toggle
    applyStimulus(8'hE0); applyStimulus(8'h75);
    runIdle(200);
    checkOutput("t3_scanCode_E0", scanCode_E0, 8'h75);
    checkOutput("t3_scanCode", scanCode, 8'h00);
    checkOutput("t3_isascii", isASCIIkey, 0);
    base = events_seen;
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
    applyStimulus(8'hE0); applyStimulus(8'h70); applyStimulus(8'hE0); applyStimulus(8'hF0);
    applyStimulus(8'h70);
    runIdle(200);
    checkOutput("t3_insert", insert, 1);
    checkOutput("t3_insert_no_event", events_seen - base, 0);

    // Held-key repeat
    base = events_seen;
    applyStimulus(8'h1C); applyStimulus(8'h1C); applyStimulus(8'h1C);
    runIdle(300);
    checkOutput("t4_repeat_events", events_seen - base, TYPEMATIC ? 3 : 1);
    applyStimulus(8'hF0); applyStimulus(8'h1C);
    runIdle(200);

    // Pause sequence swallowed, status bytes ignored
    base = events_seen;
    applyStimulus(8'hE1); applyStimulus(8'h14); applyStimulus(8'h77); applyStimulus(8'hE1);
    applyStimulus(8'hF0); applyStimulus(8'h14); applyStimulus(8'hF0); applyStimulus(8'h77);
    applyStimulus(8'h16); applyStimulus(8'hAA); applyStimulus(8'hFA);
    runIdle(300);
    checkOutput("t5_events", events_seen - base, 1);
    checkOutput("t5_scanCode", scanCode, 8'h16);
    checkOutput("t5_ascii", ASCII, 8'h31);
    checkOutput("t5_ctrl", ctrl, 0);
    applyStimulus(8'hF0); applyStimulus(8'h16);
    runIdle(200);

    // Reset between prefix and code drops the prefix
    applyStimulus(8'hE0);
    runIdle(100);
    applyReset();
    applyStimulus(8'h75);
    runIdle(200);
    checkOutput("t6_scanCode", scanCode, 8'h75);
    checkOutput("t6_scanCode_E0", scanCode_E0, 8'h00);
    applyStimulus(8'hF0); applyStimulus(8'h75);
    runIdle(200);

    // Reset in the middle of a newKey pulse
    applyStimulus(8'h24);
    begin
      int n = 0;
      while (!newKey && n < 50) begin stepCycle(); n++; end
      checkOutput("pulse_seen", newKey, 1);
    end
    stepCycle();
    applyReset();
    repeat (2) stepCycle();

    for (int t = 0; t < 400; t++) randomToken();
    runIdle(40000);
    checkOutput("final_mods", {shift, ctrl, alt, capslock, insert},
                {m_lsh | m_rsh, m_lct | m_rct, m_lal | m_ral, m_caps, m_ins});
    checkOutput("pop_in_hold_gap", pop_violations, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
